// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings ({cs_n,ras_n,cas_n,we_n}),
// arbiter state encoding and default address/bank widths.
package sdram_pkg;

  localparam int unsigned SDRAM_ADDR_W = 13;
  localparam int unsigned SDRAM_BA_W   = 2;

  localparam logic [3:0] CMD_NOP       = 4'b0111;
  localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
  localparam logic [3:0] CMD_AREFRESH  = 4'b0001;
  localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
  localparam logic [3:0] CMD_WRITE     = 4'b0100;
  localparam logic [3:0] CMD_READ      = 4'b0101;
  localparam logic [3:0] CMD_MRS       = 4'b0000;

  typedef enum logic [2:0] {
    StInit    = 3'd0,
    StIdle    = 3'd1,
    StRefresh = 3'd2,
    StWrite   = 3'd3,
    StRead    = 3'd4
  } arbit_state_e;

endpackage

// File: rtl/sdram_arbit_if.sv
// Bundle of every client handshake and SDRAM pin signal around sdram_arbit.
// Modports:
//   master - client side (init/refresh/write/read engines + pin consumer)
//   slave  - arbiter side (sdram_arbit)
// Optional macro ARBIT_BURST_BREAK_EN adds arbit_break (arbiter -> clients).
interface sdram_arbit_if #(
  parameter int unsigned ADDR_W = sdram_pkg::SDRAM_ADDR_W,
  parameter int unsigned BA_W   = sdram_pkg::SDRAM_BA_W
);

  // Init engine
  logic [3:0]        init_cmd;
  logic [ADDR_W-1:0] init_addr;
  logic              init_end;
  // Refresh engine
  logic              arbit_refresh_req;
  logic [3:0]        refresh_cmd;
  logic              refresh_end;
  logic              arbit_refresh_ack;
  // Write engine
  logic              arbit_wr_req;
  logic [3:0]        wr_cmd;
  logic [ADDR_W-1:0] wr_addr;
  logic [BA_W-1:0]   wr_ba;
  logic              wr_end;
  logic              arbit_wr_ack;
  // Read engine
  logic              arbit_rd_req;
  logic [3:0]        rd_cmd;
  logic [ADDR_W-1:0] rd_addr;
  logic [BA_W-1:0]   rd_ba;
  logic              rd_end;
  logic              arbit_rd_ack;
  // SDRAM pins
  logic [3:0]        sdram_cmd;
  logic [ADDR_W-1:0] sdram_addr;
  logic [BA_W-1:0]   sdram_ba;
`ifdef ARBIT_BURST_BREAK_EN
  logic              arbit_break;
`endif

  modport master (
`ifdef ARBIT_BURST_BREAK_EN
    input  arbit_break,
`endif
    output init_cmd, init_addr, init_end,
    output arbit_refresh_req, refresh_cmd, refresh_end,
    output arbit_wr_req, wr_cmd, wr_addr, wr_ba, wr_end,
    output arbit_rd_req, rd_cmd, rd_addr, rd_ba, rd_end,
    input  arbit_refresh_ack, arbit_wr_ack, arbit_rd_ack,
    input  sdram_cmd, sdram_addr, sdram_ba
  );

  modport slave (
`ifdef ARBIT_BURST_BREAK_EN
    output arbit_break,
`endif
    input  init_cmd, init_addr, init_end,
    input  arbit_refresh_req, refresh_cmd, refresh_end,
    input  arbit_wr_req, wr_cmd, wr_addr, wr_ba, wr_end,
    input  arbit_rd_req, rd_cmd, rd_addr, rd_ba, rd_end,
    output arbit_refresh_ack, arbit_wr_ack, arbit_rd_ack,
    output sdram_cmd, sdram_addr, sdram_ba
  );

endinterface

// File: rtl/sdram_arbit.sv
// SDRAM command/address pin arbiter. Grants the pins to one of four clients:
// init (unconditional until init_end), then refresh > write > read by fixed
// priority from IDLE. Every grant returns through IDLE, so grants are always
// separated by at least one NOP cycle.
// Ports:
//   sysclk_100M - only clock
//   rst         - synchronous, active-high reset (forces INIT)
//   bus         - sdram_arbit_if.slave: client req/ack/end handshakes,
//                 client cmd/addr/ba, and the SDRAM cmd/addr/ba pins
// Optional macro ARBIT_BURST_BREAK_EN: drives bus.arbit_break high while a
// write/read burst holds the pins and refresh is pending.
module sdram_arbit #(
  parameter int unsigned ADDR_W  = sdram_pkg::SDRAM_ADDR_W,
  parameter int unsigned BA_W    = sdram_pkg::SDRAM_BA_W,
  parameter logic [3:0]  CMD_NOP = sdram_pkg::CMD_NOP
) (
  input  logic          sysclk_100M,
  input  logic          rst,
  sdram_arbit_if.slave  bus
);

  import sdram_pkg::*;

  arbit_state_e state_q, state_d;

  logic [3:0]        cmd_mux;
  logic [ADDR_W-1:0] addr_mux;
  logic [BA_W-1:0]   ba_mux;

  // Next-state: each owner leaves only on its own *_end; a simultaneous end
  // and request always passes through IDLE before the next grant.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StInit: begin
        if (bus.init_end) state_d = StIdle;
      end
      StIdle: begin
        if (bus.arbit_refresh_req)  state_d = StRefresh;
        else if (bus.arbit_wr_req)  state_d = StWrite;
        else if (bus.arbit_rd_req)  state_d = StRead;
      end
      StRefresh: begin
        if (bus.refresh_end) state_d = StIdle;
      end
      StWrite: begin
        if (bus.wr_end) state_d = StIdle;
      end
      StRead: begin
        if (bus.rd_end) state_d = StIdle;
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge sysclk_100M) begin
    if (rst) state_q <= StInit;
    else     state_q <= state_d;
  end

  // Acks decode the registered state only; no path from any request.
  assign bus.arbit_refresh_ack = (state_q == StRefresh);
  assign bus.arbit_wr_ack      = (state_q == StWrite);
  assign bus.arbit_rd_ack      = (state_q == StRead);

  // Pin mux: zero-cycle pass-through of the current owner's registered outputs.
  always_comb begin
    cmd_mux  = CMD_NOP;
    addr_mux = '0;
    ba_mux   = '0;
    unique case (state_q)
      StInit: begin
        cmd_mux  = bus.init_cmd;
        addr_mux = bus.init_addr;
      end
      StIdle: begin
        cmd_mux = CMD_NOP;
      end
      StRefresh: begin
        cmd_mux = bus.refresh_cmd;
      end
      StWrite: begin
        cmd_mux  = bus.wr_cmd;
        addr_mux = bus.wr_addr;
        ba_mux   = bus.wr_ba;
      end
      StRead: begin
        cmd_mux  = bus.rd_cmd;
        addr_mux = bus.rd_addr;
        ba_mux   = bus.rd_ba;
      end
      default: begin
        cmd_mux = CMD_NOP;
      end
    endcase
  end

  assign bus.sdram_cmd  = cmd_mux;
  assign bus.sdram_addr = addr_mux;
  assign bus.sdram_ba   = ba_mux;

`ifdef ARBIT_BURST_BREAK_EN
  logic break_q, break_d;

  // Based on state_d so the flag drops on the same edge the burst ends.
  assign break_d = ((state_d == StWrite) || (state_d == StRead)) && bus.arbit_refresh_req;

  always_ff @(posedge sysclk_100M) begin
    if (rst) break_q <= 1'b0;
    else     break_q <= break_d;
  end

  assign bus.arbit_break = break_q;
`endif

endmodule

// File: doc/sdram_arbit.md
Name: sdram_arbit

Overview:
- Owns the SDRAM command/address pins.
- Grants them to exactly one of four clients: init, refresh, write, read.
- Sits directly downstream of the refresh controller:
  - consumes its arbit_refresh_req, cmd_reg and refresh_end;
  - returns arbit_refresh_ack.
- Same handshake is used for the write and read engines; the init engine owns the bus unconditionally until init_end.

Parameters:
- ADDR_W, 13, SDRAM row/column address width.
- BA_W, 2, bank address width.
- CMD_NOP, 4'b0111, {cs_n,ras_n,cas_n,we_n} driven when no client owns the bus.

Ports:
- sysclk_100M  in  1  system clock (100 MHz); only clock.
- rst  in  1  reset, synchronous, active-high.
- init_cmd  in  4  init engine command.
- init_addr  in  ADDR_W  init engine address (mode register value).
- init_end  in  1  1-cycle pulse: initialisation complete.
- arbit_refresh_req  in  1  refresh request level, held until ack.
- refresh_cmd  in  4  refresh engine command (its cmd_reg).
- refresh_end  in  1  1-cycle pulse: refresh sequence done.
- arbit_refresh_ack  out  1  refresh grant level.
- arbit_wr_req  in  1  write request level.
- wr_cmd  in  4  write engine command.
- wr_addr  in  ADDR_W  write engine address.
- wr_ba  in  BA_W  write engine bank.
- wr_end  in  1  1-cycle pulse: write burst done.
- arbit_wr_ack  out  1  write grant level.
- arbit_rd_req  in  1  read request level.
- rd_cmd  in  4  read engine command.
- rd_addr  in  ADDR_W  read engine address.
- rd_ba  in  BA_W  read engine bank.
- rd_end  in  1  1-cycle pulse: read burst done.
- arbit_rd_ack  out  1  read grant level.
- sdram_cmd  out  4  {cs_n,ras_n,cas_n,we_n} to pins.
- sdram_addr  out  ADDR_W  address to pins.
- sdram_ba  out  BA_W  bank to pins.

Behaviour:
- States: INIT, IDLE, REFRESH, WRITE, READ; one-hot or binary encoding, implementer's choice.
- Reset (rst=1 at a clock edge) has priority over everything:
  - state forced to INIT; all acks 0 on the next cycle.
  - sdram_cmd, sdram_addr, sdram_ba follow the INIT mux (= init_* inputs; sdram_ba = 0).
- INIT:
  - mux passes init_cmd/init_addr; sdram_ba = 0.
  - init_end -> IDLE.
  - All requests ignored; acks stay 0.
- IDLE:
  - sdram_cmd = CMD_NOP, sdram_addr = 0, sdram_ba = 0.
  - Fixed priority on the sampled request levels: refresh > write > read.
  - Highest-priority request moves to its state next cycle.
- REFRESH / WRITE / READ:
  - Matching ack = 1, registered (state-decoded, no combinational path from req).
  - Mux passes that client's cmd/addr/ba; refresh_cmd is paired with addr 0, ba 0.
  - Stay until that client's *_end is sampled high, then -> IDLE.
- Latency:
  - req sampled in IDLE at edge N -> ack high after edge N+1.
  - *_end at edge M -> ack low after edge M+1.
  - At least one IDLE (NOP) cycle between any two grants.
- Mux is combinational from current state, zero cycles from client to pins; clients register their own outputs.
- *_end from a non-owner, or init_end outside INIT: ignored.
- Request withdrawn while in IDLE: no grant; request withdrawn after grant: grant held until *_end.
- Simultaneous *_end and new requests: go to IDLE first, then arbitrate on the following edge.
- Starvation: refresh always wins in IDLE. Write/read engines must bound burst length so refresh deadline is met.

Optional Feature:
- Macro: ARBIT_BURST_BREAK_EN.
- Defined:
  - extra output arbit_break (1 bit), reset value 0.
  - arbit_break = 1 while state is WRITE or READ and arbit_refresh_req = 1.
  - owner must finish with precharge and pulse *_end; arbiter then grants refresh after one IDLE cycle.
- Undefined: port absent; refresh waits for the current burst to end naturally.

Decomposition:
- Shared package sdram_pkg:
  - command encodings CMD_NOP, CMD_PRECHARGE, CMD_AREFRESH, CMD_ACTIVE, CMD_WRITE, CMD_READ, CMD_MRS;
  - state encoding for the arbiter;
  - ADDR_W and BA_W defaults.
- No sub-module needed.
- Pin mux kept as a single always_comb block inside sdram_arbit.

Test Plan:
- Reset then init: rst=1 for 10 cycles, init_end pulse at cycle 20 -> state IDLE at cycle 21; sdram_cmd=4'b0111; all acks 0.
- Refresh handshake:
  - arbit_refresh_req=1 in IDLE at edge N -> arbit_refresh_ack=1 from N+1.
  - refresh_cmd=4'b0001 appears on sdram_cmd.
  - refresh_end at edge N+8 -> ack=0 after N+9; sdram_cmd=NOP.
- Priority:
  - refresh, write and read requests all raised in the same cycle -> refresh granted first, write next, read last.
  - Each grant is separated by exactly one NOP cycle.
- Write pass-through: grant write with wr_addr=13'h0A5, wr_ba=2'd2 -> sdram_addr=13'h0A5, sdram_ba=2 in the same cycle; rd_end pulse meanwhile -> ignored.
- Reset mid-READ:
  - rst=1 while arbit_rd_ack=1 -> ack=0 next cycle; state INIT.
  - Requests ignored until a new init_end.
- With ARBIT_BURST_BREAK_EN: raise arbit_refresh_req during WRITE -> arbit_break=1 next cycle; after wr_end -> one NOP cycle, then arbit_refresh_ack=1.
